// File: rtl/nor_logic_sequencer.sv
// Multi-cycle logic-op controller: builds NOR/OR/AND/XOR/XNOR/NOT from one shared
// external NOR unit, staging intermediates in t/u and returning result with a done pulse.
module nor_logic_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] nor_a_o,
    output logic [WIDTH-1:0] nor_b_o,
    input  logic [WIDTH-1:0] nor_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [2:0] OpNor  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpXor  = 3'd3;
    localparam logic [2:0] OpXnor = 3'd4;
    localparam logic [2:0] OpNot  = 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [2:0]       step_q;
    logic [2:0]       rop_q;
    logic [WIDTH-1:0] ra_q, rb_q, t_q, u_q;
    logic             busy_q, done_q, err_q;
    logic [WIDTH-1:0] result_q;

    logic [2:0]       last_step;
    logic             cap_u;

    always_comb begin
        last_step = 3'd0;
        case (rop_q)
            OpOr:    last_step = 3'd1;
            OpAnd:   last_step = 3'd2;
            OpXnor:  last_step = 3'd3;
            OpXor:   last_step = 3'd4;
            default: last_step = 3'd0;
        endcase
    end

    // Second step of AND/XNOR/XOR lands in u; every other intermediate lands in t.
    assign cap_u = (step_q == 3'd1) && (rop_q == OpAnd || rop_q == OpXnor || rop_q == OpXor);

    always_comb begin
        nor_a_o = '0;
        nor_b_o = '0;
        if (state_q == StRun) begin
            case (rop_q)
                OpNor: begin
                    nor_a_o = ra_q;
                    nor_b_o = rb_q;
                end
                OpNot: begin
                    nor_a_o = ra_q;
                    nor_b_o = ra_q;
                end
                OpOr: begin
                    nor_a_o = (step_q == 3'd0) ? ra_q : t_q;
                    nor_b_o = (step_q == 3'd0) ? rb_q : t_q;
                end
                OpAnd: begin
                    case (step_q)
                        3'd0:    begin nor_a_o = ra_q; nor_b_o = ra_q; end
                        3'd1:    begin nor_a_o = rb_q; nor_b_o = rb_q; end
                        default: begin nor_a_o = t_q;  nor_b_o = u_q;  end
                    endcase
                end
                OpXnor, OpXor: begin
                    case (step_q)
                        3'd0:    begin nor_a_o = ra_q; nor_b_o = rb_q; end
                        3'd1:    begin nor_a_o = ra_q; nor_b_o = t_q;  end
                        3'd2:    begin nor_a_o = rb_q; nor_b_o = t_q;  end
                        3'd3:    begin nor_a_o = u_q;  nor_b_o = t_q;  end
                        default: begin nor_a_o = t_q;  nor_b_o = t_q;  end
                    endcase
                end
                default: begin
                    nor_a_o = '0;
                    nor_b_o = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            step_q   <= '0;
            rop_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            t_q      <= '0;
            u_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (op_i <= OpNot) begin
                            ra_q    <= a_i;
                            rb_q    <= b_i;
                            rop_q   <= op_i;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end else begin
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            result_q <= '0;
                            state_q  <= StFin;
                        end
                    end
                end
                StRun: begin
                    step_q <= step_q + 3'd1;
                    if (step_q == last_step) begin
                        result_q <= nor_out_i;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= StFin;
                    end else if (cap_u) begin
                        u_q <= nor_out_i;
                    end else begin
                        t_q <= nor_out_i;
                    end
                end
                StFin: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_nor_logic_sequencer.sv
// Directed bench for nor_logic_sequencer with a behavioural NOR unit attached.
module tb_nor_logic_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] nor_a, nor_b, nor_out;
    logic        busy, done, err;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign nor_out = ~(nor_a | nor_b);

    nor_logic_sequencer #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .nor_a_o   (nor_a),
        .nor_b_o   (nor_b),
        .nor_out_i (nor_out),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .result_o  (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one legal op; k is the expected number of RUN cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int k, input logic [31:0] exp_r,
                          input bit hold);
        logic [31:0] exp_b0;
        exp_b0 = (o == 3'd2 || o == 3'd5) ? av : bv;
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        a = ~av; b = ~bv; op = 3'd6;
        chk({tag, "_nor_a0"}, nor_a, av);
        chk({tag, "_nor_b0"}, nor_b, exp_b0);
        for (int i = 0; i < k; i++) begin
            chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done_run"}, {31'd0, done}, 32'd0);
            tick();
        end
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_nor_a_fin"}, nor_a, 32'd0);
        tick();
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_no_reissue"}, {31'd0, busy | done}, 32'd0);
        chk({tag, "_result_hold"}, result, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_nor_a", nor_a, 32'd0);
        chk("rst_nor_b", nor_b, 32'd0);
        reset = 1'b0;
        tick();

        run_op("and",  3'd2, 32'hF0F0_1234, 32'hFF00_FFFF, 3, 32'hF000_1234, 1'b0);
        run_op("xor",  3'd3, 32'hAAAA_AAAA, 32'hFFFF_0000, 5, 32'h5555_AAAA, 1'b0);
        run_op("xnor", 3'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 4, 32'hAAAA_5555, 1'b0);
        run_op("or",   3'd1, 32'h0000_00FF, 32'h0F00_0000, 2, 32'h0F00_00FF, 1'b1);

        // Illegal op: immediate done+err, result forced to 0, NOR unit untouched.
        op = 3'd6; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_done", {31'd0, done}, 32'd1);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_busy", {31'd0, busy}, 32'd0);
        chk("ill_result", result, 32'd0);
        chk("ill_nor_a", nor_a, 32'd0);
        chk("ill_nor_b", nor_b, 32'd0);
        tick();
        chk("ill_done_after", {31'd0, done}, 32'd0);
        chk("ill_busy_after", {31'd0, busy}, 32'd0);
        chk("ill_err_held", {31'd0, err}, 32'd1);
        tick();

        run_op("not", 3'd5, 32'hFFFF_FFFF, 32'h1234_5678, 1, 32'h0000_0000, 1'b0);
        run_op("nor", 3'd0, 32'h0000_0000, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1'b0);

        // Abort an XOR mid-run with reset; no done may follow.
        op = 3'd3; a = 32'hAAAA_AAAA; b = 32'hFFFF_0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_nor_a", nor_a, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", {31'd0, done | busy}, 32'd0);
        end

        run_op("and2", 3'd2, 32'h0F0F_FFFF, 32'h00FF_1234, 3, 32'h000F_1234, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_logic_sequencer.md
Name: nor_logic_sequencer

Overview:
- Multi-cycle controller that realises the full 32-bit logic op set (NOR, OR, AND, XOR, XNOR, NOT) using one shared, externally instantiated nor32 unit as its only logic resource.
- Sits between the ALU control decode and the nor32 instance.
- Drives the NOR operands each cycle, captures the NOR output into internal temporaries, and returns the result with a done pulse.

Parameters:
- WIDTH, 32, operand/result width; must match the attached NOR unit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  0=NOR, 1=OR, 2=AND, 3=XOR, 4=XNOR, 5=NOT_A, 6/7=illegal.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- nor_a  output  WIDTH  operand to shared NOR unit.
- nor_b  output  WIDTH  operand to shared NOR unit.
- nor_out  input  WIDTH  combinational result from shared NOR unit.
- busy  output  1  high while sequencing.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  high with done when op was illegal.
- result  output  WIDTH  final value; held until the next accepted start completes.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, step=0.
  - busy=0, done=0, err=0, result=0.
  - Internal regs ra, rb, t, u cleared.
  - nor_a=nor_b=0.
- States: IDLE, RUN, FIN.
- IDLE: nor_a=nor_b=0, busy=0.
  - start=1 with legal op: latch a->ra, b->rb, op->rop; step=0; go to RUN.
  - start=1 with illegal op: latch nothing; go to FIN with err flag set; result forced to 0.
- RUN: busy=1.
  - nor_a/nor_b are a combinational function of (rop, step, ra, rb, t, u).
  - nor_out is captured at the clock edge into the register named below.
  - step increments each cycle.
- Step schedule (k = step count):
  - NOR (k=1): result=nor(ra,rb).
  - NOT_A (k=1): result=nor(ra,ra).
  - OR (k=2): t=nor(ra,rb); result=nor(t,t).
  - AND (k=3): t=nor(ra,ra); u=nor(rb,rb); result=nor(t,u).
  - XNOR (k=4): t=nor(ra,rb); u=nor(ra,t); t=nor(rb,t); result=nor(u,t).
  - XOR (k=5): the four XNOR steps with the last capture into t; then result=nor(t,t).
- On the final step's edge: result is written and state goes to FIN.
- FIN (one cycle): done=1, busy=0, err=1 only if illegal; next state IDLE.
- Latency: start cycle C; RUN occupies C+1..C+k; done is high in C+k+1.
  - Illegal op: done and err in C+1.
- Back-to-back: start is sampled again in the cycle after FIN, so minimum issue interval is k+2 cycles.
- start while RUN or FIN is ignored; it is not queued.
- a, b and op may change freely after acceptance; only latched copies are used.
- result changes only on the final-step edge or on reset. It is never partially updated; temporaries live in t/u only.
- err clears when the next done is issued for a legal op, or on reset.
- reset asserted mid-RUN: the edge returns to IDLE with all outputs at reset values. No done is issued for the aborted op.
- reset has priority over start in the same cycle.
- Exactly one NOR evaluation per RUN cycle. The NOR unit is free (operands 0) in IDLE and FIN.

Test Plan:
- Reset, then op=2 (AND), a=0xF0F0_1234, b=0xFF00_FFFF, start one cycle -> busy high 3 cycles; done in cycle 4 after start; result=0xF000_1234, err=0.
- op=3 (XOR), a=0xAAAA_AAAA, b=0xFFFF_0000 -> done in start+6; result=0x5555_AAAA. Then op=4 (XNOR) on same operands -> result=0xAAAA_5555, done at start+5.
- op=1 (OR), a=0x0000_00FF, b=0x0F00_0000; hold start high through RUN with different a/b -> exactly one done at start+3; result=0x0F00_00FF; extra starts ignored.
- op=0 (NOR) a=b=0 -> result=0xFFFF_FFFF at start+2. op=5 (NOT_A) a=0xFFFF_FFFF -> result=0.
- op=6 with start -> done=1 and err=1 at start+1; result=0; busy never asserted; nor_a/nor_b stay 0.
- Start XOR; assert reset during RUN step 3 -> next cycle busy=0, done=0, result=0; no done pulse follows. A fresh AND request then completes normally.
